// File: rtl/reed_solomon_decoder_wr_combiner.sv
// Packs RS decoder output bytes into cache lines held in a ring of ping-pong slots for the c1 write path.
// Optional: define RS_WRCOMB_DROP_CNT_EN to add a saturating dropped_count output.
module reed_solomon_decoder_wr_combiner #(
    parameter int NUM_LINES  = 2,
    parameter int LINE_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              data_in,
    input  logic                    valid_in,
    input  logic                    flush,
    output logic [8*LINE_BYTES-1:0] line_data,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic [31:0]             line_count,
    output logic                    overflow,
    output logic                    busy
`ifdef RS_WRCOMB_DROP_CNT_EN
    ,
    output logic [31:0]             dropped_count
`endif
);

    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int PTR_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int IDX_W  = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILLING,
        S_FULL
    } slot_state_e;

    slot_state_e       slot_state     [NUM_LINES];
    slot_state_e       slot_state_nxt [NUM_LINES];
    logic [LINE_W-1:0] slot_data      [NUM_LINES];

    logic [PTR_W-1:0]     fill_ptr;
    logic [PTR_W-1:0]     pop_ptr;
    logic [IDX_W-1:0]     byte_idx;
    logic [NUM_LINES-1:0] full_vec;

    logic fill_full;
    logic accept;
    logic drop;
    logic complete;
    logic close_line;
    logic pop;

    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            full_vec[i] = (slot_state[i] == S_FULL);
        end
    end

    // Slots fill and drain in ring order, so the fill slot is FULL only when every slot is waiting.
    assign fill_full  = full_vec[fill_ptr];
    assign accept     = valid_in && !fill_full;
    assign drop       = valid_in && fill_full;
    assign complete   = accept && (byte_idx == LAST_IDX);
    assign close_line = complete || (flush && ((byte_idx != '0) || accept));
    assign pop        = full_vec[pop_ptr] && line_ready;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            slot_state_nxt[i] = slot_state[i];
        end
        if (pop) begin
            slot_state_nxt[pop_ptr] = S_EMPTY;
        end
        if (accept && (slot_state[fill_ptr] == S_EMPTY)) begin
            slot_state_nxt[fill_ptr] = S_FILLING;
        end
        if (close_line) begin
            slot_state_nxt[fill_ptr] = S_FULL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                slot_state[i] <= S_EMPTY;
            end
            fill_ptr   <= '0;
            pop_ptr    <= '0;
            byte_idx   <= '0;
            line_count <= '0;
            overflow   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                slot_state[i] <= slot_state_nxt[i];
            end
            if (pop) begin
                pop_ptr    <= pop_ptr + PTR_W'(1);
                line_count <= line_count + 32'd1;
            end
            if (close_line) begin
                fill_ptr <= fill_ptr + PTR_W'(1);
                byte_idx <= '0;
            end else if (accept) begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the line store is reset because line_data must read zero after reset and padding relies on cleared slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            // Pop and fill never target the same slot: one needs FULL, the other needs not FULL.
            if (pop) begin
                slot_data[pop_ptr] <= '0;
            end
            for (int k = 0; k < LINE_BYTES; k++) begin
                if (accept && (byte_idx == IDX_W'(k))) begin
                    slot_data[fill_ptr][LINE_W-8-8*k +: 8] <= data_in;
                end
            end
        end
    end

`ifdef RS_WRCOMB_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped_count <= '0;
        end else if (drop && (dropped_count != 32'hFFFF_FFFF)) begin
            dropped_count <= dropped_count + 32'd1;
        end
    end
`endif

    assign line_data  = slot_data[pop_ptr];
    assign line_valid = full_vec[pop_ptr];
    assign busy       = (|full_vec) || (byte_idx != '0);

endmodule

// File: tb/tb_reed_solomon_decoder_wr_combiner.sv
// Directed scoreboard bench for reed_solomon_decoder_wr_combiner: a byte-packing model predicts each line.
module tb_reed_solomon_decoder_wr_combiner;

    localparam int LB = 64;
    localparam int NL = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        data_in = '0;
    logic              valid_in = 1'b0;
    logic              flush = 1'b0;
    logic [8*LB-1:0]   line_data;
    logic              line_valid;
    logic              line_ready = 1'b0;
    logic [31:0]       line_count;
    logic              overflow;
    logic              busy;
`ifdef RS_WRCOMB_DROP_CNT_EN
    logic [31:0]       dropped_count;
`endif

    reed_solomon_decoder_wr_combiner #(
        .NUM_LINES (NL),
        .LINE_BYTES(LB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .flush     (flush),
        .line_data (line_data),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_count(line_count),
        .overflow  (overflow),
        .busy      (busy)
`ifdef RS_WRCOMB_DROP_CNT_EN
        ,
        .dropped_count(dropped_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [8*LB-1:0] exp_q [$];
    logic [8*LB-1:0] m_line = '0;
    int              m_idx  = 0;
    int              pops   = 0;
    int              drops  = 0;

    task automatic check(input string tag, input logic [8*LB-1:0] obs, input logic [8*LB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic close_model();
        exp_q.push_back(m_line);
        m_line = '0;
        m_idx  = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; the model decides drops against pre-edge slot occupancy.
    task automatic drive(input logic [7:0] b, input logic v, input logic f);
        @(posedge clk);
        #1;
        data_in  = b;
        valid_in = v;
        flush    = f;
        if (v) begin
            if (exp_q.size() == NL) begin
                drops++;
            end else begin
                m_line[8*(LB-1-m_idx) +: 8] = b;
                m_idx++;
                if (m_idx == LB) close_model();
            end
        end
        if (f && m_idx != 0) close_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic feed(input int n, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < n; i++) drive(base + 8'(i) * step, 1'b1, 1'b0);
    endtask

    // Scoreboard: a transfer seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && line_valid && line_ready) begin
            check("pop_line_count", 512'(line_count), 512'(pops));
            check("pop_expected", 512'(exp_q.size() != 0), 512'(1));
            if (exp_q.size() != 0) check("pop_line_data", line_data, exp_q.pop_front());
            pops++;
        end
    end

    initial begin
        #22;
        reset_n = 1'b1;
        #1;
        check("rst_line_valid", 512'(line_valid), 512'(0));
        check("rst_line_data", line_data, '0);
        check("rst_line_count", 512'(line_count), 512'(0));
        check("rst_overflow", 512'(overflow), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));

        // Single line, ready held high: one-cycle valid pulse.
        line_ready = 1'b1;
        feed(LB, 8'h00, 8'h01);
        idle(1);
        check("t1_valid_pulse", 512'(line_valid), 512'(1));
        idle(1);
        check("t1_valid_drop", 512'(line_valid), 512'(0));
        check("t1_line_count", 512'(line_count), 512'(1));

        // Two lines queued behind a stalled consumer.
        line_ready = 1'b0;
        feed(2*LB, 8'h11, 8'h03);
        idle(1);
        check("t2_valid", 512'(line_valid), 512'(1));
        check("t2_busy", 512'(busy), 512'(1));
        check("t2_overflow", 512'(overflow), 512'(0));
        check("t2_head", line_data, exp_q[0]);
        idle(5);
        check("t2_head_hold", line_data, exp_q[0]);
        check("t2_valid_hold", 512'(line_valid), 512'(1));
        line_ready = 1'b1;
        idle(4);
        check("t2_line_count", 512'(line_count), 512'(3));
        check("t2_idle", 512'(busy), 512'(0));

        // Partial line closed by flush, then a no-op flush.
        feed(10, 8'hA0, 8'h01);
        drive(8'h00, 1'b0, 1'b1);
        idle(1);
        check("t3_flush_valid", 512'(line_valid), 512'(1));
        drive(8'h00, 1'b0, 1'b1);
        idle(3);
        check("t3_empty_flush", 512'(line_count), 512'(4));
        check("t3_busy", 512'(busy), 512'(0));
        // Byte and flush together: byte lands first.
        drive(8'h55, 1'b1, 1'b1);
        idle(3);
        check("t3_flush_byte", 512'(line_count), 512'(5));

        // Line completes in the same cycle the previous one pops.
        line_ready = 1'b0;
        feed(LB, 8'h40, 8'h05);
        feed(LB-1, 8'h80, 8'h07);
        drive(8'hEE, 1'b1, 1'b0);
        line_ready = 1'b1;
        idle(4);
        check("t4_line_count", 512'(line_count), 512'(7));
        check("t4_busy", 512'(busy), 512'(0));

        // Overrun: 129 bytes into two stalled slots.
        line_ready = 1'b0;
        feed(2*LB, 8'h23, 8'h0B);
        idle(1);
        check("t5_no_overflow", 512'(overflow), 512'(0));
        drive(8'hFF, 1'b1, 1'b0);
        idle(1);
        check("t5_overflow", 512'(overflow), 512'(1));
`ifdef RS_WRCOMB_DROP_CNT_EN
        check("t5_dropped_count", 512'(dropped_count), 512'(drops));
`endif
        line_ready = 1'b1;
        idle(4);
        check("t5_line_count", 512'(line_count), 512'(9));
        check("t5_overflow_sticky", 512'(overflow), 512'(1));

        // Reset mid-line discards the partial line.
        feed(30, 8'h61, 8'h01);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("t6_rst_valid", 512'(line_valid), 512'(0));
        check("t6_rst_busy", 512'(busy), 512'(0));
        check("t6_rst_count", 512'(line_count), 512'(0));
        check("t6_rst_overflow", 512'(overflow), 512'(0));
        exp_q.delete();
        m_line = '0;
        m_idx  = 0;
        pops   = 0;
        drops  = 0;
        #10;
        reset_n = 1'b1;
        feed(LB, 8'hC3, 8'h01);
        idle(4);
        check("t6_clean_line", 512'(line_count), 512'(1));
        check("t6_idle", 512'(busy), 512'(0));

        check("queue_drained", 512'(exp_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
